// File: rtl/rv_muldiv_pkg.sv
// Shared encodings for the RV32M/RV64M multiply/divide unit.
// Holds the funct3 op codes, the FSM state encoding and op-class helpers.
package rv_muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  function automatic logic is_div(input logic [2:0] f3);
    return f3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
  endfunction

endpackage

// File: rtl/rv_muldiv_sign_fix.sv
// Final step: conditional two's-complement negate and result select.
// Purely combinational; product negation spans the full 2*XLEN width.
module rv_muldiv_sign_fix #(
  parameter int XLEN = 32
) (
  input  logic [2:0]        f3,
  input  logic              neg,
  input  logic [2*XLEN-1:0] acc,
  output logic [XLEN-1:0]   res
);
  import rv_muldiv_pkg::*;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;

  // acc holds the unsigned product for multiplies, {remainder, quotient} for divides
  always_comb begin
    prod = neg ? (2*XLEN)'(0) - acc : acc;
    quot = neg ? XLEN'(0) - acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg ? XLEN'(0) - acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (f3)
      F3_MUL:                      res = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: res = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             res = quot;
      default:                     res = rem;
    endcase
  end

endmodule

// File: rtl/rv_muldiv_unit.sv
// Iterative M-extension unit: XLEN+1 edges for mul/div, 1 edge for div special cases
// (and for multiplies when RV_MULDIV_FAST_MUL_EN is defined). start ignored while busy; flush aborts.
module rv_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import rv_muldiv_pkg::*;

  localparam int CNT_W = $clog2(XLEN);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   opd_q, opd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;

  logic              accept;
  logic              sa, sb, neg_e0;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, div_next;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   rem_sub;
  logic              rem_ge;
  logic [XLEN-1:0]   fix_res;
`ifdef RV_MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
`endif

  // Operand decode at the accepting edge
  always_comb begin
    accept   = (state_q == ST_IDLE) && start && !flush;
    sa       = (funct3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM}) && op_a[XLEN-1];
    sb       = (funct3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM}) && op_b[XLEN-1];
    mag_a    = sa ? XLEN'(0) - op_a : op_a;
    mag_b    = sb ? XLEN'(0) - op_b : op_b;
    neg_e0   = (funct3 == F3_REM) ? sa : (sa ^ sb);
    div_zero = is_div(funct3) && (op_b == '0);
    div_ovf  = (funct3 inside {F3_DIV, F3_REM}) && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    special  = div_zero || div_ovf;
`ifdef RV_MULDIV_FAST_MUL_EN
    fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif
  end

  // One iteration step of each algorithm
  always_comb begin
    mul_sum  = acc_q[0] ? {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opd_q}
                        : {1'b0, acc_q[2*XLEN-1:XLEN]};
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    rem_ge   = rem_sh >= {1'b0, opd_q};
    rem_sub  = rem_sh[XLEN-1:0] - opd_q;
    div_next = {(rem_ge ? rem_sub : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], rem_ge};
  end

  rv_muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .f3  (f3_q),
    .neg (neg_q),
    .acc (acc_q),
    .res (fix_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef RV_MULDIV_FAST_MUL_EN
          state_d = (special || !is_div(funct3)) ? ST_FIX : ST_CALC;
`else
          state_d = special ? ST_FIX : ST_CALC;
`endif
        end
      end
      ST_CALC: if (cnt_q == '0) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_comb begin
    busy   = (state_q != ST_IDLE);
    done   = done_q;
    result = result_q;
  end

  always_comb begin
    f3_d     = f3_q;
    opd_d    = opd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          f3_d  = funct3;
          cnt_d = CNT_W'(XLEN-1);
          neg_d = neg_e0;
          if (is_div(funct3)) begin
            opd_d = mag_b;
            acc_d = {{XLEN{1'b0}}, mag_a};
            // Special-case answers are preloaded as {remainder, quotient}, unsigned
            if (div_zero) begin
              acc_d = {op_a, {XLEN{1'b1}}};
              neg_d = 1'b0;
            end else if (div_ovf) begin
              acc_d = {{XLEN{1'b0}}, op_a};
              neg_d = 1'b0;
            end
          end else begin
            opd_d = mag_a;
`ifdef RV_MULDIV_FAST_MUL_EN
            acc_d = fast_prod;
`else
            acc_d = {{XLEN{1'b0}}, mag_b};
`endif
          end
        end
      end
      ST_CALC: begin
        acc_d = is_div(f3_q) ? div_next : mul_next;
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      ST_FIX: begin
        if (!flush) begin
          result_d = fix_res;
          done_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      f3_q     <= '0;
      opd_q    <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      opd_q    <= opd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Self-checking bench for rv_muldiv_unit (XLEN=32): directed table, random ops vs a
// plain-arithmetic reference, and hand sequences for busy/start/flush/reset behaviour.
module tb_rv_muldiv_unit;
  import rv_muldiv_pkg::*;

`ifdef RV_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  rv_muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa = {{32{a[31]}}, a};
    logic signed [63:0] sb = {{32{b[31]}}, b};
    logic signed [63:0] ua = {32'b0, a};
    logic signed [63:0] ub = {32'b0, b};
    logic signed [63:0] p;
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      F3_MUL:    begin p = sa * sb; return p[31:0];  end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * ub; return p[63:32]; end
      F3_MULHU:  begin p = ua * ub; return p[63:32]; end
      F3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      F3_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      F3_REM: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!(f3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU})) return MUL_LAT;
    if (b == 0) return 1;
    if ((f3 inside {F3_DIV, F3_REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return DIV_LAT;
  endfunction

  // Issues one op, scrambles the inputs after acceptance, and returns result plus
  // the number of edges from the accepting edge to the one that raised done (0 = timeout).
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    funct3 = f3; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom_range(0, 7));
    res = 'x; lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done) begin
        res = result; lat = k;
        break;
      end
    end
  endtask

  vec_t        vecs [12];
  logic [31:0] res;
  int          lat;
  int          busy_cnt;
  int          done_cnt;
  logic [31:0] ra, rb;
  logic [2:0]  rf;

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;

    vecs[0]  = '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
    vecs[1]  = '{F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT};
    vecs[2]  = '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
    vecs[3]  = '{F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT};
    vecs[4]  = '{F3_DIV,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, DIV_LAT};
    vecs[5]  = '{F3_REM,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, DIV_LAT};
    vecs[6]  = '{F3_DIVU,   32'd100,        32'd7,         32'd14,        DIV_LAT};
    vecs[7]  = '{F3_REMU,   32'd100,        32'd7,         32'd2,         DIV_LAT};
    vecs[8]  = '{F3_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{F3_REMU,   32'd5,          32'd0,         32'd5,         1};
    vecs[10] = '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk) reset = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, res, lat);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // busy/done shape of a multiply
    @(negedge clk);
    funct3 = F3_MUL; op_a = 32'd7; op_b = 32'hFFFF_FFFD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = busy ? 1 : 0; done_cnt = 0; res = 'x;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; res = result; end
    end
    chk("mul_busy_cycles", 32'(busy_cnt), 32'(MUL_LAT));
    chk("mul_done_cycles", 32'(done_cnt), 32'd1);
    chk("mul_result", res, 32'hFFFF_FFEB);

    // start while busy is ignored
    @(negedge clk);
    funct3 = F3_DIVU; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 0; res = 'x;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 10) begin
        start = 1'b1; funct3 = F3_MUL; op_a = 32'd3; op_b = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin res = result; lat = k; break; end
    end
    chk("busy_start_result", res, 32'd14);
    chk("busy_start_latency", 32'(lat), 32'(DIV_LAT));
    repeat (2) @(posedge clk);
    #1;
    chk("busy_start_no_second_op", 32'(busy), 32'd0);

    // flush mid-operation
    @(negedge clk);
    funct3 = F3_DIVU; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_done", 32'(done), 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    chk("flush_no_done", 32'(done_cnt), 32'd0);
    chk("flush_result_held", result, 32'd14);

    // flush beats a simultaneous start
    @(negedge clk);
    funct3 = F3_DIVU; op_a = 32'd9; op_b = 32'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start_idle", 32'(busy), 32'd0);

    // asynchronous reset mid-CALC
    @(negedge clk);
    funct3 = F3_DIV; op_a = 32'hFFFF_FFEC; op_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("areset_busy", 32'(busy), 32'd0);
    chk("areset_done", 32'(done), 32'd0);
    chk("areset_result", result, 32'd0);
    @(negedge clk) reset = 1'b0;
    run_op(F3_DIV, 32'hFFFF_FFEC, 32'd3, res, lat);
    chk("post_reset_result", res, 32'hFFFF_FFFA);
    chk("post_reset_latency", 32'(lat), 32'(DIV_LAT));

    // random ops against the reference model
    for (int n = 0; n < 250; n++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(rf, ra, rb, res, lat);
      chk($sformatf("rand%0d_f3=%0d_a=%h_b=%h_result", n, rf, ra, rb), res, ref_res(rf, ra, rb));
      chk($sformatf("rand%0d_latency", n), 32'(lat), 32'(ref_lat(rf, ra, rb)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_muldiv_unit.md
Name: rv_muldiv_unit

Overview:
- Parametrised iterative RV32M/RV64M multiply/divide unit for the pipelined core. It executes all eight M-extension ops.
- The EX stage issues an op with a start pulse and stalls on busy. The result is returned with a one-cycle done pulse.
- Shift-add multiply and restoring divide, one bit per cycle, with operand magnitudes and a final sign-fix step.

Parameters:
- XLEN, 32, operand/result width (power of 2, ≥8)
- CNT_W, $clog2(XLEN), iteration counter width (derived; not overridden)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request; sampled only in IDLE
- funct3  in  3  M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  XLEN  rs1 value
- op_b  in  XLEN  rs2 value
- flush  in  1  synchronous kill from the branch/exception path
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse; result valid in the same cycle
- result  out  XLEN  registered result; holds until the next done

Behaviour:
- Reset (asynchronous):
  - state=IDLE, busy=0, done=0, result=0, counter=0, internal accumulators=0.
  - Reset during an operation aborts it with no done.
- States: IDLE, CALC, FIX.
- IDLE, start=1, flush=0 (accepting edge E0):
  - Latch funct3.
  - Latch |op_a| and |op_b| as signed or unsigned per op. MULHSU: op_a signed, op_b unsigned.
  - Latch result sign and special-case flags.
  - Load counter=XLEN-1; go to CALC.
- Special cases bypass CALC (E0 goes straight to FIX):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = op_a.
  - Signed overflow (op_a = most negative, op_b = -1): DIV = op_a; REM = 0.
- CALC, multiply: each edge conditionally adds the multiplicand into the upper half of a 2·XLEN product, then shifts right 1.
- CALC, divide: each edge shifts the remainder/quotient pair left 1 and subtracts when the remainder ≥ divisor (restoring).
- CALC exit: when counter=0, go to FIX; otherwise decrement.
- FIX (one edge):
  - Apply two's-complement negation if the result sign is set.
  - Select the output: low half for MUL, high half for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU.
  - Register result, assert done=1 for exactly one cycle, return to IDLE.
- Sign rules: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a); product sign = XOR of the signed operands' signs.
- Latency:
  - Normal ops: done is high after edge E0+XLEN+1 (33 edges for XLEN=32).
  - Special cases: done is high after edge E0+1.
- start while busy=1: ignored. No queueing; operands are not re-latched.
- flush=1 in any state: the next edge goes to IDLE, no done, result unchanged. flush wins over a simultaneous start.
- done and a new start may coincide: start is accepted on the edge after done, because the state is IDLE then.
- Operands are sampled only at E0. Changes to op_a, op_b or funct3 during CALC have no effect.

Optional Feature:
- Macro: RV_MULDIV_FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHSU/MULHU compute the full 2·XLEN signed product combinationally at E0 and go directly to FIX.
  - Multiply latency is 1 edge. Divide is unchanged.
  - Intended for FPGA DSP inference.
- Undefined: all multiplies are iterative with XLEN+1 edge latency as above.

Decomposition:
- Package rv_muldiv_pkg holds:
  - funct3 localparams (F3_MUL … F3_REMU)
  - 2-bit state encoding (ST_IDLE, ST_CALC, ST_FIX)
  - an is_div(funct3) helper function
- Sub-module rv_muldiv_sign_fix: combinational conditional negate plus output half/quotient/remainder select. It is used by FIX and kept separately unit-testable.
- The datapath registers and FSM remain in the top module.

Test Plan (XLEN=32):
- MUL a=7, b=0xFFFFFFFD → result 0xFFFFFFEB; done exactly 33 edges after accept; busy high for those 33 cycles; done high for exactly one cycle.
- MULH 0x80000000·0x80000000 → 0x40000000.
- MULHU 0xFFFFFFFF·0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV −20/3 → 0xFFFFFFFA; REM −20%3 → 0xFFFFFFFE; DIVU 100/7 → 14; REMU 100%7 → 2.
- DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0; each has done 1 edge after accept.
- Robustness:
  - start pulsed at cycle 10 of a busy op → ignored; the first result is unchanged.
  - flush at cycle 5 → busy low next cycle, no done, result keeps its prior value.
  - Async reset asserted mid-CALC → busy=0, done=0, result=0 immediately, without waiting for a clock edge.
- With RV_MULDIV_FAST_MUL_EN defined: MUL 7·(−3) → 0xFFFFFFEB with done 1 edge after accept; DIV −20/3 still 33 edges.
